mux3_rr_select: RTL
===================

// Module: mux3_rr_select
// PURPOSE
//  Upstream select generator for the 3:1 mux stage. Arbitrates round-robin among
//  three requesters and drives {s0,s1} so the mux passes the granted source.
//  Holds the select stable for a burst of up to BURST_LEN beats with a
//  valid/ready handshake, so the mux output never glitches mid-burst.
// PARAMETERS
//  BURST_LEN  4                     max beats per grant before forced re-arbitration (>=1)
//  CNT_W      $clog2(BURST_LEN+1)   beat counter width (derived, do not override)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   3      per-source request; req[k] = source ik has data
//  req_last   in   3      per-source end-of-burst marker, sampled only on a transfer
//  out_ready  in   1      downstream consumer of mux output accepts a beat
//  s0         out  1      mux select MSB
//  s1         out  1      mux select LSB
//  gnt        out  3      one-hot grant, 0 when idle
//  out_valid  out  1      granted source valid at mux output
//  beat_cnt   out  CNT_W  beats transferred in current burst
// BEHAVIOUR
//  - Select encoding: i0 -> {s0,s1}=2'b00, i1 -> 2'b10, i2 -> 2'b11. 2'b01 never driven.
//  - Reset (async assert, sync deassert in system): state=IDLE, gnt=0, {s0,s1}=00,
//    beat_cnt=0, rr pointer=2 (so i0 wins first), out_valid=0. Reset mid-burst
//    aborts the burst immediately; no partial state survives.
//  - States: IDLE, BUSY.
//    IDLE: if |req, pick first requester after pointer (order 0->1->2->0);
//      gnt/{s0,s1} registered -> visible 1 cycle after req sampled; -> BUSY.
//    BUSY: out_valid = req[granted] (combinational). Transfer = out_valid & out_ready.
//      Each transfer: beat_cnt++.
//      Burst end on transfer when beat_cnt==BURST_LEN-1 OR req_last[granted]=1;
//      also when req[granted] drops (abandon, no transfer counted).
//  - Burst end: pointer<=granted index; re-arbitrate same cycle on current req with
//    updated pointer; if any request, new gnt next cycle, stay BUSY, beat_cnt<=0
//    (zero-bubble back-to-back). If none: -> IDLE, gnt=0, {s0,s1} hold last value.
//  - Same requester re-granted only if it is the sole requester at burst end.
//  - {s0,s1} and gnt change only on the clock after a burst end or IDLE grant; never
//    while out_valid=1 without burst end.
//  - req_last and counter terminal on same beat: single burst end, no double count.
//  - out_ready low: beat_cnt holds, grant holds indefinitely (no timeout).
//  - req_last ignored when no transfer or when bit is not the granted source.
//  - BURST_LEN=1: every transfer ends the burst; pure per-beat round-robin.
//  - beat_cnt never exceeds BURST_LEN-1; wraps to 0 only at burst end.
// STRUCTURE
//  - Package mux3_sel_pkg: state typedef {IDLE,BUSY}; localparams SEL_I0=2'b00,
//    SEL_I1=2'b10, SEL_I2=2'b11; function idx_to_sel(idx)->2-bit select.
//  - Sub-module rr_pick3: combinational round-robin picker
//    (req[2:0], ptr[1:0]) -> (any, idx[1:0]); instantiated once.
//  - Top: FSM, pointer reg, beat counter, registered gnt/select.
// TESTING
//  1 Reset: rst_n=0 mid-burst -> gnt=000, {s0,s1}=00, out_valid=0, beat_cnt=0 at once.
//  2 req=111 held, out_ready=1, BURST_LEN=4 -> grants i0,i1,i2,i0 each 4 beats; sel
//    00,10,11,00; no idle cycle between bursts.
//  3 req=010, req_last[1] on beat 2 -> burst ends after 2 beats, gnt=010 re-issued
//    next cycle (sole requester), beat_cnt restarts at 0.
//  4 Grant i2, out_ready=0 for 10 cycles -> sel=11, beat_cnt=0 held; then 4 beats.
//  5 Grant i1, req[1] drops after 1 beat with req[0] high -> next cycle gnt=001,
//    sel=00, pointer=1 so subsequent order i2,i0.
//  6 Assert every cycle: $onehot0(gnt); {s0,s1}!=2'b01; sel stable while BUSY
//    and no burst end.

Source files
------------

// File: rtl/mux3_sel_pkg.sv
// Shared types and helpers for the round-robin 3:1 mux select generator.
package mux3_sel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b10;
    localparam logic [1:0] SEL_I2 = 2'b11;

    // Source index to {s0,s1}; the 2'b01 code is never produced.
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        case (idx)
            2'd1:    return SEL_I1;
            2'd2:    return SEL_I2;
            default: return SEL_I0;
        endcase
    endfunction

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // (idx + step) mod 3 for idx in 0..3 and step in 0..3.
    function automatic logic [1:0] wrap3(input logic [1:0] idx, input logic [1:0] step);
        logic [2:0] s;
        s = 3'(idx) + 3'(step);
        if (s >= 3'd3) s = s - 3'd3;
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/mux3_rr_select_if.sv
// Request/grant/select bundle between the requesters, the select generator and the mux.
interface mux3_rr_select_if #(
    parameter int unsigned BURST_LEN = 4
);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    logic [2:0]       req;
    logic [2:0]       req_last;
    logic             out_ready;
    logic             s0;
    logic             s1;
    logic [2:0]       gnt;
    logic             out_valid;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        output req, req_last, out_ready,
        input  s0, s1, gnt, out_valid, beat_cnt
    );

    modport slave (
        input  req, req_last, out_ready,
        output s0, s1, gnt, out_valid, beat_cnt
    );
endinterface

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping 0->1->2->0.
module rr_pick3
    import mux3_sel_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;

    assign c1 = wrap3(ptr, 2'd1);
    assign c2 = wrap3(ptr, 2'd2);
    assign c3 = wrap3(ptr, 2'd3);

    // c3 is the pointer itself: the last holder wins only when alone.
    always_comb begin
        any = 1'b0;
        idx = 2'd0;
        if (|(req & idx_to_onehot(c1))) begin
            any = 1'b1;
            idx = c1;
        end else if (|(req & idx_to_onehot(c2))) begin
            any = 1'b1;
            idx = c2;
        end else if (|(req & idx_to_onehot(c3))) begin
            any = 1'b1;
            idx = c3;
        end
    end

endmodule

// File: rtl/mux3_rr_select.sv
// Round-robin select generator for a 3:1 mux; holds the select for a whole burst.
module mux3_rr_select
    import mux3_sel_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux3_rr_select_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gidx_q, gidx_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       valid_c;
    logic       xfer_c;
    logic       last_c;
    logic       abandon_c;
    logic       burst_end_c;
    logic [1:0] pick_ptr_c;
    logic       pick_any_c;
    logic [1:0] pick_idx_c;

    // The grant register is one-hot, so masking with it selects the granted bit.
    assign valid_c     = (state_q == BUSY) && |(bus.req & gnt_q);
    assign xfer_c      = valid_c && bus.out_ready;
    assign last_c      = xfer_c && ((cnt_q == CNT_LAST) || |(bus.req_last & gnt_q));
    assign abandon_c   = (state_q == BUSY) && !(|(bus.req & gnt_q));
    assign burst_end_c = last_c || abandon_c;

    // At burst end the pointer is about to become the granted index; arbitrate with it now.
    assign pick_ptr_c = (state_q == BUSY) ? gidx_q : ptr_q;

    rr_pick3 u_pick (
        .req (bus.req),
        .ptr (pick_ptr_c),
        .any (pick_any_c),
        .idx (pick_idx_c)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any_c) begin
                    state_d = BUSY;
                    gidx_d  = pick_idx_c;
                    gnt_d   = idx_to_onehot(pick_idx_c);
                    sel_d   = idx_to_sel(pick_idx_c);
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (burst_end_c) begin
                    ptr_d = gidx_q;
                    cnt_d = '0;
                    if (pick_any_c) begin
                        gidx_d = pick_idx_c;
                        gnt_d  = idx_to_onehot(pick_idx_c);
                        sel_d  = idx_to_sel(pick_idx_c);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Pointer resets to 2 so source 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd2;
            gidx_q  <= 2'd0;
            gnt_q   <= '0;
            sel_q   <= SEL_I0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.s0        = sel_q[1];
    assign bus.s1        = sel_q[0];
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = valid_c;
    assign bus.beat_cnt  = cnt_q;

endmodule
